// File: rtl/element_stream_compactor.sv
// Repacks sparse, misaligned element chunks into dense beats of up to N elements,
// never mixing two bursts in one beat, and throttles the upstream reader by buffer headroom.
module element_stream_compactor #(
    parameter int ELEM_BITS             = 16,
    parameter int NUM_PARALLEL_ELEMENTS = 4,
    parameter int MAX_CHUNKS_IN_FLIGHT  = 8,
    parameter int DEPTH                 = 64,
    localparam int N     = NUM_PARALLEL_ELEMENTS,
    localparam int OFF_W = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        element_packet_valid,
    input  logic [N-1:0][ELEM_BITS-1:0] elements,
    input  logic [OFF_W-1:0]            chunk_offset,
    input  logic [CNT_W-1:0]            chunk_length,
    input  logic                        last,
    output logic                        is_ready_to_receive_lots_of_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0][ELEM_BITS-1:0] out_elements,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_last,
    output logic                        overflow
);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int FILL_W     = $clog2(DEPTH + 1);
    localparam int READY_FREE = N * (MAX_CHUNKS_IN_FLIGHT + 1);

    logic [ELEM_BITS-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]            r_eob;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [FILL_W-1:0]           r_fill;
    logic                        r_out_valid;
    logic [N-1:0][ELEM_BITS-1:0] r_out_elements;
    logic [CNT_W-1:0]            r_out_count;
    logic                        r_out_last;
    logic                        r_overflow;
    logic                        r_ready;

    logic [FILL_W-1:0]           w_free;
    logic [FILL_W-1:0]           w_fill_next;
    logic                        w_write;
    logic                        w_load;
    logic                        w_found;
    logic                        w_eligible;
    logic [CNT_W-1:0]            w_taken;
    logic [N-1:0][ELEM_BITS-1:0] w_beat;
    logic [N-1:0]                w_lane_en;
    logic [N-1:0]                w_lane_eob;
    logic [N-1:0][PTR_W-1:0]     w_lane_addr;

    // Free space is judged before any same-cycle read, so a chunk never relies on a pending pop.
    assign w_free  = FILL_W'(DEPTH) - r_fill;
    assign w_write = element_packet_valid && !areset && (FILL_W'(chunk_length) <= w_free);

    always_comb begin
        w_lane_en   = '0;
        w_lane_eob  = '0;
        w_lane_addr = '0;
        for (int i = 0; i < N; i++) begin
            if ((i >= int'(chunk_offset)) && (i < int'(chunk_offset) + int'(chunk_length))) begin
                w_lane_en[i]   = w_write;
                w_lane_addr[i] = r_wr_ptr + PTR_W'(i - int'(chunk_offset));
                w_lane_eob[i]  = last && (i == int'(chunk_offset) + int'(chunk_length) - 1);
            end
        end
    end

    // Gather up to N oldest elements, stopping right after the first end-of-burst marker.
    always_comb begin
        w_taken = '0;
        w_found = 1'b0;
        w_beat  = '0;
        for (int j = 0; j < N; j++) begin
            if ((FILL_W'(j) < r_fill) && !w_found) begin
                w_beat[j] = r_mem[r_rd_ptr + PTR_W'(j)];
                w_taken   = CNT_W'(j + 1);
                w_found   = r_eob[r_rd_ptr + PTR_W'(j)];
            end
        end
        w_eligible = (r_fill >= FILL_W'(N)) || w_found;
    end

    assign w_load      = w_eligible && (!r_out_valid || out_ready);
    assign w_fill_next = r_fill
                       + (w_write ? FILL_W'(chunk_length) : FILL_W'(0))
                       - (w_load  ? FILL_W'(w_taken)      : FILL_W'(0));

    always_ff @(posedge aclk) begin
        for (int i = 0; i < N; i++) begin
            if (w_lane_en[i]) begin
                r_mem[w_lane_addr[i]] <= elements[i];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_eob          <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fill         <= '0;
            r_out_valid    <= 1'b0;
            r_out_elements <= '0;
            r_out_count    <= '0;
            r_out_last     <= 1'b0;
            r_overflow     <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_lane_en[i]) begin
                    r_eob[w_lane_addr[i]] <= w_lane_eob[i];
                end
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(chunk_length);
            end
            if (element_packet_valid && !w_write) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_rd_ptr       <= r_rd_ptr + PTR_W'(w_taken);
                r_out_valid    <= 1'b1;
                r_out_elements <= w_beat;
                r_out_count    <= w_taken;
                r_out_last     <= w_found;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_fill  <= w_fill_next;
            r_ready <= (FILL_W'(DEPTH) - w_fill_next) >= FILL_W'(READY_FREE);
        end
    end

    assign is_ready_to_receive_lots_of_data = r_ready;
    assign out_valid    = r_out_valid;
    assign out_elements = r_out_elements;
    assign out_count    = r_out_count;
    assign out_last     = r_out_last;
    assign overflow     = r_overflow;
endmodule

// File: tb/tb_element_stream_compactor.sv
// Bench for element_stream_compactor: directed scenarios with constant expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_element_stream_compactor;
    localparam int EB    = 16;
    localparam int N     = 4;
    localparam int MCIF  = 8;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [EB-1:0] data;
        logic          eob;
    } ent_t;

    typedef struct packed {
        logic [2:0]           cnt;
        logic                 lst;
        logic [N-1:0][EB-1:0] data;
    } beat_t;

    logic                 aclk = 1'b0;
    logic                 areset = 1'b0;
    logic                 element_packet_valid = 1'b0;
    logic [N-1:0][EB-1:0] elements = '0;
    logic [1:0]           chunk_offset = '0;
    logic [2:0]           chunk_length = '0;
    logic                 last = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 is_ready_to_receive_lots_of_data;
    logic                 out_valid;
    logic [N-1:0][EB-1:0] out_elements;
    logic [2:0]           out_count;
    logic                 out_last;
    logic                 overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: buffered elements as a plain queue plus the output register.
    ent_t                 mq[$];
    bit                   mv, mlast, movf, mrdy;
    int                   mcnt;
    logic [N-1:0][EB-1:0] mdata;

    beat_t                obs_q[$];
    logic [EB-1:0]        exp_q[$];
    logic [EB-1:0]        got_q[$];

    element_stream_compactor dut (
        .aclk                             (aclk),
        .areset                           (areset),
        .element_packet_valid             (element_packet_valid),
        .elements                         (elements),
        .chunk_offset                     (chunk_offset),
        .chunk_length                     (chunk_length),
        .last                             (last),
        .is_ready_to_receive_lots_of_data (is_ready_to_receive_lots_of_data),
        .out_valid                        (out_valid),
        .out_ready                        (out_ready),
        .out_elements                     (out_elements),
        .out_count                        (out_count),
        .out_last                         (out_last),
        .overflow                         (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic model_edge();
        int   free;
        int   taken;
        bit   found;
        ent_t e;
        if (areset) begin
            mq.delete();
            mv = 0; mlast = 0; movf = 0; mrdy = 0; mcnt = 0; mdata = '0;
            return;
        end
        free  = DEPTH - mq.size();
        taken = 0;
        found = 0;
        while (taken < N && taken < mq.size() && !found) begin
            found = mq[taken].eob;
            taken++;
        end
        if ((mq.size() >= N || found) && (!mv || out_ready)) begin
            mv = 1; mcnt = taken; mlast = found; mdata = '0;
            for (int j = 0; j < taken; j++) begin
                e = mq.pop_front();
                mdata[j] = e.data;
            end
        end else if (mv && out_ready) begin
            mv = 0;
        end
        if (element_packet_valid) begin
            if (int'(chunk_length) > free) begin
                movf = 1;
            end else begin
                for (int j = 0; j < int'(chunk_length); j++) begin
                    e.data = elements[int'(chunk_offset) + j];
                    e.eob  = last && (j == int'(chunk_length) - 1);
                    mq.push_back(e);
                end
            end
        end
        mrdy = (DEPTH - mq.size()) >= N * (MCIF + 1);
    endtask

    task automatic cycle(input bit v, input logic [N-1:0][EB-1:0] el, input int off,
                         input int len, input bit lst, input bit rdy);
        beat_t b;
        element_packet_valid = v;
        elements     = el;
        chunk_offset = 2'(off);
        chunk_length = 3'(len);
        last         = lst;
        out_ready    = rdy;
        if (out_valid === 1'b1 && out_ready) begin
            b.cnt = out_count; b.lst = out_last; b.data = out_elements;
            obs_q.push_back(b);
        end
        model_edge();
        @(posedge aclk);
        #1;
        element_packet_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 1, 0, rdy);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle(2, 0);
        areset = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic void flatten();
        got_q.delete();
        foreach (obs_q[b]) begin
            for (int j = 0; j < int'(obs_q[b].cnt); j++) got_q.push_back(obs_q[b].data[j]);
        end
    endfunction

    task automatic test_reset();
        logic [N-1:0][EB-1:0] el;
        for (int l = 0; l < N; l++) el[l] = 16'(l + 1);
        areset = 1'b1;
        idle(1, 0);
        cycle(1, el, 0, 4, 1, 1);
        n_cmp++; if (is_ready_to_receive_lots_of_data !== 1'b0) begin n_bad++; $display("FAIL reset_rdy_in_reset: got %b expected 0", is_ready_to_receive_lots_of_data); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_in_reset: got %b expected 0", out_valid); end
        areset = 1'b0;
        idle(1, 1);
        n_cmp++; if (is_ready_to_receive_lots_of_data !== 1'b1) begin n_bad++; $display("FAIL reset_rdy_release: got %b expected 1", is_ready_to_receive_lots_of_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_cmp++; if (out_count !== 3'd0 || out_last !== 1'b0 || out_elements !== '0) begin n_bad++; $display("FAIL reset_outputs: got count %0d last %b data %h expected zeros", out_count, out_last, out_elements); end
        for (int i = 0; i < 4; i++) begin
            idle(1, 1);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_aligned();
        logic [N-1:0][EB-1:0] el;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < N; l++) el[l] = 16'(c * 4 + l);
            cycle(1, el, 0, 4, c == 2, 1);
            if (c == 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL aligned_early: got %b expected 0", out_valid); end
            end
            if (c == 1) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL aligned_latency: got %b expected 1", out_valid); end
            end
        end
        idle(4, 1);
        n_cmp++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL aligned_nbeats: got %0d expected 3", obs_q.size()); end
        for (int b = 0; b < obs_q.size() && b < 3; b++) begin
            n_cmp++; if (obs_q[b].cnt !== 3'd4 || obs_q[b].lst !== (b == 2)) begin n_bad++; $display("FAIL aligned_beat%0d: got count %0d last %b expected 4 %b", b, obs_q[b].cnt, obs_q[b].lst, b == 2); end
        end
        flatten();
        n_cmp++; if (got_q.size() != 12) begin n_bad++; $display("FAIL aligned_len: got %0d expected 12", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 12; i++) begin
            n_cmp++; if (got_q[i] !== 16'(i)) begin n_bad++; $display("FAIL aligned_data[%0d]: got %0d expected %0d", i, got_q[i], i); end
        end
    endtask

    task automatic test_misaligned();
        logic [N-1:0][EB-1:0] el;
        int exp_cnt[2] = '{4, 3};
        do_reset();
        el = {16'd101, 16'd100, 16'hdead, 16'hbeef};
        cycle(1, el, 2, 2, 0, 1);
        el = {16'd105, 16'd104, 16'd103, 16'd102};
        cycle(1, el, 0, 4, 0, 1);
        el = {16'd106, 16'hdead, 16'hdead, 16'hdead};
        cycle(1, el, 3, 1, 1, 1);
        idle(4, 1);
        n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL misaligned_nbeats: got %0d expected 2", obs_q.size()); end
        for (int b = 0; b < obs_q.size() && b < 2; b++) begin
            n_cmp++; if (int'(obs_q[b].cnt) != exp_cnt[b] || obs_q[b].lst !== (b == 1)) begin n_bad++; $display("FAIL misaligned_beat%0d: got count %0d last %b expected %0d %b", b, obs_q[b].cnt, obs_q[b].lst, exp_cnt[b], b == 1); end
        end
        flatten();
        for (int i = 0; i < 7; i++) exp_q.push_back(16'(100 + i));
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL misaligned_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL misaligned_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0][EB-1:0] el;
        int exp_cnt[3] = '{3, 4, 1};
        bit exp_lst[3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        el = {16'hdead, 16'd202, 16'd201, 16'd200};
        cycle(1, el, 0, 3, 1, 1);
        el = {16'd206, 16'd205, 16'd204, 16'd203};
        cycle(1, el, 0, 4, 0, 1);
        el = {16'hdead, 16'hdead, 16'hdead, 16'd207};
        cycle(1, el, 0, 1, 1, 1);
        idle(4, 1);
        n_cmp++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL b2b_nbeats: got %0d expected 3", obs_q.size()); end
        for (int b = 0; b < obs_q.size() && b < 3; b++) begin
            n_cmp++; if (int'(obs_q[b].cnt) != exp_cnt[b] || obs_q[b].lst !== exp_lst[b]) begin n_bad++; $display("FAIL b2b_beat%0d: got count %0d last %b expected %0d %b", b, obs_q[b].cnt, obs_q[b].lst, exp_cnt[b], exp_lst[b]); end
        end
        flatten();
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            n_cmp++; if (got_q[i] !== 16'(200 + i)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, got_q[i], 200 + i); end
        end
    endtask

    task automatic test_flow_control();
        logic [N-1:0][EB-1:0] el;
        logic [N-1:0][EB-1:0] first;
        first = {16'd303, 16'd302, 16'd301, 16'd300};
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            for (int l = 0; l < N; l++) el[l] = 16'(300 + 4 * (t - 1) + l);
            cycle(1, el, 0, 4, 0, 0);
            // Held beat occupies 4 elements outside the buffer; buffer holds 4*(t-1) after edge t.
            n_cmp++; if (is_ready_to_receive_lots_of_data !== (t <= 8)) begin n_bad++; $display("FAIL fc_rdy_t%0d: got %b expected %b", t, is_ready_to_receive_lots_of_data, t <= 8); end
            if (t >= 2) begin
                n_cmp++; if (out_valid !== 1'b1 || out_elements !== first) begin n_bad++; $display("FAIL fc_hold_t%0d: got valid %b data %h expected 1 %h", t, out_valid, out_elements, first); end
            end
        end
        for (int d = 1; d <= 40 && obs_q.size() < 10; d++) begin
            cycle(0, '0, 0, 1, 0, 1);
            if (d == 1) begin
                n_cmp++; if (is_ready_to_receive_lots_of_data !== 1'b0) begin n_bad++; $display("FAIL fc_drain1_rdy: got %b expected 0", is_ready_to_receive_lots_of_data); end
            end
            if (d == 2) begin
                n_cmp++; if (is_ready_to_receive_lots_of_data !== 1'b1) begin n_bad++; $display("FAIL fc_drain2_rdy: got %b expected 1", is_ready_to_receive_lots_of_data); end
            end
        end
        n_cmp++; if (obs_q.size() != 10) begin n_bad++; $display("FAIL fc_drain_timeout: got %0d beats expected 10", obs_q.size()); end
        flatten();
        for (int i = 0; i < got_q.size() && i < 40; i++) begin
            n_cmp++; if (got_q[i] !== 16'(300 + i)) begin n_bad++; $display("FAIL fc_data[%0d]: got %0d expected %0d", i, got_q[i], 300 + i); end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0][EB-1:0] el;
        do_reset();
        for (int t = 1; t <= 18; t++) begin
            for (int l = 0; l < N; l++) el[l] = 16'(1000 + 4 * (t - 1) + l);
            cycle(1, el, 0, 4, 0, 0);
            if (t == 17) begin
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_t17: got %b expected 0", overflow); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            idle(1, 0);
            n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        end
        for (int d = 0; d < 60 && (obs_q.size() < 17 || out_valid === 1'b1); d++) cycle(0, '0, 0, 1, 0, 1);
        n_cmp++; if (obs_q.size() != 17) begin n_bad++; $display("FAIL ovf_nbeats: got %0d expected 17", obs_q.size()); end
        flatten();
        for (int i = 0; i < got_q.size() && i < 68; i++) begin
            n_cmp++; if (got_q[i] !== 16'(1000 + i)) begin n_bad++; $display("FAIL ovf_data[%0d]: got %0d expected %0d", i, got_q[i], 1000 + i); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_after_drain: got %b expected 1", overflow); end
        do_reset();
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_reset_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_random();
        logic [N-1:0][EB-1:0] el;
        int rp[3] = '{90, 15, 50};
        int off, len;
        bit v, lst, rdy;
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int c = 0; c < 800; c++) begin
                for (int l = 0; l < N; l++) el[l] = 16'($urandom);
                v   = ($urandom_range(0, 99) < 70);
                off = $urandom_range(0, N - 1);
                len = $urandom_range(1, N - off);
                lst = ($urandom_range(0, 3) == 0);
                rdy = ($urandom_range(0, 99) < rp[ph]);
                cycle(v, el, off, len, lst, rdy);
                n_cmp++; if (out_valid !== mv) begin n_bad++; $display("FAIL rnd_valid p%0d c%0d: got %b expected %b", ph, c, out_valid, mv); end
                n_cmp++; if (is_ready_to_receive_lots_of_data !== mrdy) begin n_bad++; $display("FAIL rnd_rdy p%0d c%0d: got %b expected %b", ph, c, is_ready_to_receive_lots_of_data, mrdy); end
                n_cmp++; if (overflow !== movf) begin n_bad++; $display("FAIL rnd_ovf p%0d c%0d: got %b expected %b", ph, c, overflow, movf); end
                if (mv) begin
                    n_cmp++; if (out_count !== 3'(mcnt) || out_last !== mlast) begin n_bad++; $display("FAIL rnd_beat p%0d c%0d: got count %0d last %b expected %0d %b", ph, c, out_count, out_last, mcnt, mlast); end
                    for (int j = 0; j < mcnt; j++) begin
                        n_cmp++; if (out_elements[j] !== mdata[j]) begin n_bad++; $display("FAIL rnd_lane%0d p%0d c%0d: got %h expected %h", j, ph, c, out_elements[j], mdata[j]); end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_back_to_back();
        test_flow_control();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/element_stream_compactor.md
Name: element_stream_compactor

Overview:
- Sits directly downstream of axi_memory_burst_reader. Consumes its element packets: elements[], chunk_offset, chunk_length, last, and an element_packet_valid strobe with no backpressure.
- Repacks the sparse, misaligned chunks into dense output beats of up to NUM_PARALLEL_ELEMENTS elements, with a valid/ready handshake toward compute.
- Drives the reader's is_ready_to_receive_lots_of_data flow-control input so the buffer cannot overflow with MAX_CHUNKS_IN_FLIGHT chunks still in flight.

Parameters:
- ELEM_BITS, 16: width of one element.
- NUM_PARALLEL_ELEMENTS, 4: elements per input chunk and per output beat (N).
- MAX_CHUNKS_IN_FLIGHT, 8: chunks the reader may still deliver after ready is deasserted.
- DEPTH, 64: element buffer depth. Power of two, and must be ≥ N*(MAX_CHUNKS_IN_FLIGHT+2).

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- element_packet_valid  in  1  input chunk strobe
- elements  in  N x ELEM_BITS  chunk lanes
- chunk_offset  in  clog2(N)  first valid lane
- chunk_length  in  clog2(N+1)  valid lanes, 1..N
- last  in  1  chunk ends the burst
- is_ready_to_receive_lots_of_data  out  1  flow control to the reader
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_elements  out  N x ELEM_BITS  packed beat; lane 0 is the oldest element
- out_count  out  clog2(N+1)  valid lanes in the beat, 1..N, always lanes 0..count-1
- out_last  out  1  beat contains the burst's final element
- overflow  out  1  sticky error flag

Behaviour:
- Storage: circular buffer of DEPTH entries, each entry {data, eob}. eob marks the final element of a chunk that arrived with last=1. Registers: wr_ptr, rd_ptr, fill (0..DEPTH).
- Write: on a rising edge with element_packet_valid=1, lanes chunk_offset .. chunk_offset+chunk_length-1 are written in ascending lane order at wr_ptr onward.
  - wr_ptr advances by chunk_length, mod DEPTH, wrapping freely.
  - eob is set only on the final written element, and only when last=1.
  - Lanes beyond N-1 are never referenced. chunk_offset+chunk_length>N is illegal input, no defined behaviour.
- Overflow: free = DEPTH - fill is evaluated before any same-cycle read (conservative).
  - If chunk_length > free, the whole chunk is dropped and overflow is set.
  - overflow clears only on reset. Existing data is untouched.
- Output register: beat fields are registered.
  - Loads when (out_valid=0 or out_ready=1) and a beat is eligible. Otherwise out_valid drops to 0 after a handshake, or holds.
  - While out_valid=1 and out_ready=0, all out_* fields are held stable.
- Beat formation: let k = min(N, fill).
  - Take elements rd_ptr .. rd_ptr+k-1, truncated just after the first eob.
  - Eligible if fill ≥ N, or if an eob lies within those k elements.
  - out_count = number taken. out_last = 1 iff the taken set ends on an eob.
  - A beat never spans two bursts.
  - Fewer than N elements without an eob wait for more input; there is no timeout.
- Pointer update: rd_ptr advances by out_count when the beat loads. fill_next = fill + written - taken. Simultaneous write and load in one cycle are both applied.
- Latency: an element written at edge k can be in out_elements after edge k+1, i.e. out_valid=1 from cycle k+1.
- Flow control: is_ready_to_receive_lots_of_data is registered, set to (DEPTH - fill_next) ≥ N*(MAX_CHUNKS_IN_FLIGHT+1). Elements held in the output register do not count toward fill.
- Reset: the cycle after areset=1 leaves pointers and fill at 0, eob flags cleared, and every output at 0: out_valid, out_count, out_last, out_elements, overflow, is_ready_to_receive_lots_of_data. areset has priority over a same-cycle write. Reset mid-burst discards all buffered and held data.

Test Plan:
- Reset release, no input → is_ready_to_receive_lots_of_data=1 after the first edge with areset=0; out_valid=0, overflow=0 indefinitely.
- Three chunks, offset 0, length 4, values 0..11, last on the third, out_ready=1 → beats {0,1,2,3} count 4 last 0, {4..7} count 4 last 0, {8..11} count 4 last 1. The first beat is valid the cycle after the first chunk's edge.
- Misaligned chunks (off 2, len 2: 100,101), (off 0, len 4: 102..105), (off 3, len 1, last: 106) → beats {100..103} count 4 last 0, then {104,105,106} count 3 last 1.
- Burst A of 3 elements (last), then burst B of 5 elements (last), back-to-back → beats count 3 last 1, count 4 last 0, count 1 last 1. No merging across last.
- out_ready=0, one full chunk per cycle → one beat held stable in the output register.
  - is_ready stays 1 while free ≥ 36; it drops to 0 the cycle after the chunk that takes free below 36.
  - Raising out_ready drains the data in order, and is_ready returns to 1 once free ≥ 36.
- out_ready=0, 18 consecutive full chunks → the first 17 are kept (64 buffered plus 4 in the output register); the 18th is dropped.
  - overflow rises after the 18th edge and stays 1.
  - On draining, values match the first 17 chunks exactly.
  - Applying areset clears overflow.
